// File: rtl/controller_unit_pkg.sv
// ============================================================================
// Module : defines (package)
// Brief  : Shared widths, opcode/ALU encodings and control bundle for the
//          decode-stage controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package defines;

    localparam int OP_CODE_LEN = 4;
    localparam int EXE_CMD_LEN = 4;

    typedef enum logic [OP_CODE_LEN-1:0] {
        OP_ADD  = 4'b0000,
        OP_ADDI = 4'b0001,
        OP_SUB  = 4'b0010,
        OP_SUBI = 4'b0011,
        OP_MOV  = 4'b0100,
        OP_CMP  = 4'b0101,
        OP_LSL  = 4'b0110,
        OP_LSR  = 4'b0111,
        OP_AND  = 4'b1000,
        OP_ORR  = 4'b1001,
        OP_BEQ  = 4'b1010,
        OP_BNE  = 4'b1011,
        OP_LDR  = 4'b1100,
        OP_STR  = 4'b1101,
        OP_B    = 4'b1110,
        OP_NOP  = 4'b1111
    } opcode_e;

    typedef enum logic [EXE_CMD_LEN-1:0] {
        EXE_NOP = 4'b0000,
        EXE_ADD = 4'b0001,
        EXE_SUB = 4'b0010,
        EXE_AND = 4'b0011,
        EXE_ORR = 4'b0100,
        EXE_MOV = 4'b0101,
        EXE_LSL = 4'b0110,
        EXE_LSR = 4'b0111
    } exe_cmd_e;

    localparam logic [3:0] BR_NONE = 4'b0000;
    localparam logic [3:0] BR_BEQ  = 4'b0001;
    localparam logic [3:0] BR_BNE  = 4'b0010;
    localparam logic [3:0] BR_B    = 4'b0100;

    typedef struct packed {
        logic       branch_en;
        exe_cmd_e   exe_cmd;
        logic [3:0] branch_cmd;
        logic       is_imm;
        logic       is_str;
        logic       is_ldr;
        logic       is_cmp;
        logic       wb_en;
        logic       mem_r_en;
        logic       mem_w_en;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // Register-register/immediate ALU op that writes back.
    function automatic ctrl_t alu_ctrl(input exe_cmd_e cmd, input logic imm);
        ctrl_t c;
        c         = CTRL_BUBBLE;
        c.exe_cmd = cmd;
        c.is_imm  = imm;
        c.wb_en   = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t branch_ctrl(input logic [3:0] br);
        ctrl_t c;
        c            = CTRL_BUBBLE;
        c.branch_en  = 1'b1;
        c.branch_cmd = br;
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/controller_unit_decoder.sv
// ============================================================================
// Module : control_decoder
// Brief  : Purely combinational opcode to control-bundle decode.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module control_decoder
    import defines::*;
(
    input  logic [OP_CODE_LEN-1:0] opCode,
    output ctrl_t                  ctrl_o
);

    always_comb begin
        ctrl_o = CTRL_BUBBLE;
        case (opCode)
            OP_ADD:  ctrl_o = alu_ctrl(EXE_ADD, 1'b0);
            OP_ADDI: ctrl_o = alu_ctrl(EXE_ADD, 1'b1);
            OP_SUB:  ctrl_o = alu_ctrl(EXE_SUB, 1'b0);
            OP_SUBI: ctrl_o = alu_ctrl(EXE_SUB, 1'b1);
            OP_MOV:  ctrl_o = alu_ctrl(EXE_MOV, 1'b1);
            OP_CMP: begin
                // Flags-only subtract: no register write-back.
                ctrl_o.exe_cmd = EXE_SUB;
                ctrl_o.is_cmp  = 1'b1;
            end
            OP_LSL:  ctrl_o = alu_ctrl(EXE_LSL, 1'b0);
            OP_LSR:  ctrl_o = alu_ctrl(EXE_LSR, 1'b0);
            OP_AND:  ctrl_o = alu_ctrl(EXE_AND, 1'b0);
            OP_ORR:  ctrl_o = alu_ctrl(EXE_ORR, 1'b0);
            OP_BEQ:  ctrl_o = branch_ctrl(BR_BEQ);
            OP_BNE:  ctrl_o = branch_ctrl(BR_BNE);
            OP_LDR: begin
                ctrl_o          = alu_ctrl(EXE_ADD, 1'b1);
                ctrl_o.is_ldr   = 1'b1;
                ctrl_o.mem_r_en = 1'b1;
            end
            OP_STR: begin
                ctrl_o.exe_cmd  = EXE_ADD;
                ctrl_o.is_imm   = 1'b1;
                ctrl_o.is_str   = 1'b1;
                ctrl_o.mem_w_en = 1'b1;
            end
            OP_B:    ctrl_o = branch_ctrl(BR_B);
            OP_NOP:  ctrl_o = CTRL_BUBBLE;
            // Unknown/X opcodes fall here and decode as NOP.
            default: ctrl_o = CTRL_BUBBLE;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/controller_unit.sv
// ============================================================================
// Module : controller_unit
// Brief  : Decode-stage main controller; registered outputs form the control
//          half of the ID/EX pipeline register, with hazard bubble insertion.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module controller_unit
    import defines::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [OP_CODE_LEN-1:0] opCode,
    input  logic                   hazard_detected,
    output logic                   branchEn,
    output logic [EXE_CMD_LEN-1:0] EXE_CMD,
    output logic [3:0]             Branch_command,
    output logic                   Is_Imm,
    output logic                   Is_Str,
    output logic                   Is_Ldr,
    output logic                   Is_Cmp,
    output logic                   WB_EN,
    output logic                   MEM_R_EN,
    output logic                   MEM_W_EN
);

    ctrl_t dec_ctrl;
    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    control_decoder u_decoder (
        .opCode (opCode),
        .ctrl_o (dec_ctrl)
    );

    always_comb begin
        ctrl_d = dec_ctrl;
        if (hazard_detected) begin
            ctrl_d = CTRL_BUBBLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= CTRL_BUBBLE;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign branchEn       = ctrl_q.branch_en;
    assign EXE_CMD        = ctrl_q.exe_cmd;
    assign Branch_command = ctrl_q.branch_cmd;
    assign Is_Imm         = ctrl_q.is_imm;
    assign Is_Str         = ctrl_q.is_str;
    assign Is_Ldr         = ctrl_q.is_ldr;
    assign Is_Cmp         = ctrl_q.is_cmp;
    assign WB_EN          = ctrl_q.wb_en;
    assign MEM_R_EN       = ctrl_q.mem_r_en;
    assign MEM_W_EN       = ctrl_q.mem_w_en;

endmodule

`default_nettype wire

// File: tb/tb_controller_unit.sv
// ============================================================================
// Module : tb_controller_unit
// Brief  : Scoreboard bench for controller_unit using directed opcode vectors.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_controller_unit;

    logic       clk;
    logic       rst_n;
    logic [3:0] opCode;
    logic       hazard_detected;
    logic       branchEn;
    logic [3:0] EXE_CMD;
    logic [3:0] Branch_command;
    logic       Is_Imm, Is_Str, Is_Ldr, Is_Cmp, WB_EN, MEM_R_EN, MEM_W_EN;

    controller_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .opCode          (opCode),
        .hazard_detected (hazard_detected),
        .branchEn        (branchEn),
        .EXE_CMD         (EXE_CMD),
        .Branch_command  (Branch_command),
        .Is_Imm          (Is_Imm),
        .Is_Str          (Is_Str),
        .Is_Ldr          (Is_Ldr),
        .Is_Cmp          (Is_Cmp),
        .WB_EN           (WB_EN),
        .MEM_R_EN        (MEM_R_EN),
        .MEM_W_EN        (MEM_W_EN)
    );

    // Packed view: {branchEn, EXE[3:0], BR[3:0], imm, str, ldr, cmp, wb, mr, mw}
    logic [15:0] dut_v;
    assign dut_v = {branchEn, EXE_CMD, Branch_command, Is_Imm, Is_Str, Is_Ldr,
                    Is_Cmp, WB_EN, MEM_R_EN, MEM_W_EN};

    typedef struct {
        int          due;
        logic [15:0] exp;
        string       nm;
    } sb_t;

    sb_t q[$];
    int  cyc   = 0;
    int  total = 0;
    int  bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] model(input logic [3:0] op);
        case (op)
            4'b0000: model = {1'b0, 4'h1, 4'h0, 7'b0000100};
            4'b0001: model = {1'b0, 4'h1, 4'h0, 7'b1000100};
            4'b0010: model = {1'b0, 4'h2, 4'h0, 7'b0000100};
            4'b0011: model = {1'b0, 4'h2, 4'h0, 7'b1000100};
            4'b0100: model = {1'b0, 4'h5, 4'h0, 7'b1000100};
            4'b0101: model = {1'b0, 4'h2, 4'h0, 7'b0001000};
            4'b0110: model = {1'b0, 4'h6, 4'h0, 7'b0000100};
            4'b0111: model = {1'b0, 4'h7, 4'h0, 7'b0000100};
            4'b1000: model = {1'b0, 4'h3, 4'h0, 7'b0000100};
            4'b1001: model = {1'b0, 4'h4, 4'h0, 7'b0000100};
            4'b1010: model = {1'b1, 4'h0, 4'h1, 7'b0000000};
            4'b1011: model = {1'b1, 4'h0, 4'h2, 7'b0000000};
            4'b1100: model = {1'b0, 4'h1, 4'h0, 7'b1010110};
            4'b1101: model = {1'b0, 4'h1, 4'h0, 7'b1100001};
            4'b1110: model = {1'b1, 4'h0, 4'h4, 7'b0000000};
            default: model = 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] expect_now();
        if (!rst_n || hazard_detected || $isunknown(opCode)) return 16'h0000;
        return model(opCode);
    endfunction

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Inputs change 1 ns after a rising edge; the next edge captures them.
    task automatic step(input logic [3:0] op, input logic hz, input string nm);
        sb_t e;
        @(posedge clk);
        #1;
        opCode          = op;
        hazard_detected = hz;
        e.due = cyc + 1;
        e.exp = expect_now();
        e.nm  = nm;
        q.push_back(e);
    endtask

    task automatic assert_rst_midcycle();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        if (q.size() > 0 && q[q.size()-1].due == cyc + 1) q[q.size()-1].exp = 16'h0000;
        #1;
        check("midcycle_reset_clear", dut_v, 16'h0000);
    endtask

    task automatic release_rst(input string nm);
        sb_t e;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        if (q.size() > 0 && q[q.size()-1].due == cyc + 1) begin
            q[q.size()-1].exp = expect_now();
        end else begin
            e.due = cyc + 1;
            e.exp = expect_now();
            e.nm  = nm;
            q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due < cyc) begin
            total++;
            bad++;
            $display("FAIL missed_%s got=none want=%h", q[0].nm, q[0].exp);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].due == cyc) begin
            check(q[0].nm, dut_v, q[0].exp);
            void'(q.pop_front());
        end
        if (cyc > 0) begin
            check("inv_branchEn", {15'd0, branchEn}, {15'd0, Branch_command != 4'd0});
            check("inv_ldr_memr", {15'd0, Is_Ldr}, {15'd0, MEM_R_EN});
            check("inv_str_memw", {15'd0, Is_Str}, {15'd0, MEM_W_EN});
            check("inv_mem_excl", {15'd0, MEM_R_EN & MEM_W_EN}, 16'h0000);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n           = 1'b1;
        opCode          = 4'b0101;
        hazard_detected = 1'b0;
        #1 rst_n = 1'b0;
        #1 check("reset_no_clock", dut_v, 16'h0000);
        repeat (2) @(posedge clk);
        #1 check("reset_held_edges", dut_v, 16'h0000);
        release_rst("first_cmp");

        step(4'b1100, 1'b0, "ldr");
        step(4'b1101, 1'b0, "str");
        step(4'b1010, 1'b0, "beq");
        step(4'b0000, 1'b0, "add");
        step(4'b1000, 1'b0, "and");
        step(4'b1000, 1'b1, "and_hazard");
        step(4'b1000, 1'b1, "and_hazard2");
        step(4'b1000, 1'b0, "and_after_hazard");

        for (int i = 0; i < 16; i++) begin
            step(4'(i), 1'b0, $sformatf("sweep_op%0h", i));
        end

        step(4'bxxxx, 1'b0, "x_opcode");
        step(4'b0001, 1'b0, "addi");

        step(4'b1100, 1'b0, "pre_rst_ldr");
        step(4'b1101, 1'b0, "pre_rst_str");
        assert_rst_midcycle();
        step(4'b0000, 1'b0, "in_rst_add");
        step(4'b1110, 1'b0, "in_rst_b");
        step(4'b0100, 1'b0, "in_rst_mov");
        release_rst("post_rst_mov");
        step(4'b1011, 1'b0, "bne");
        step(4'b1111, 1'b0, "nop");

        for (int k = 0; k < 5 && q.size() > 0; k++) @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0 pending", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
